// File: rtl/uart_tx_rr_arbiter.sv
// uart_tx_rr_arbiter
//
// Shares one uart_transmitter between N requesters. A pending request is
// picked round-robin, its byte is latched onto tx_data and tx_start is
// pulsed for one cycle. The transmitter's busy flag is then tracked through
// the frame, and the winner gets a one-cycle ack when the frame ends. If
// busy never rises within BUSY_TO cycles of tx_start, the transfer is
// abandoned and the winner gets ack together with err. Priority then
// rotates to the requester after the winner.
//
// Ports
//   clk       system clock
//   rst       synchronous active-high reset
//   req       per-requester request, held high until its ack
//   req_data  flattened bytes, requester k owns [k*WIDTH +: WIDTH]
//   ack       one-cycle pulse, winner's byte finished or abandoned
//   grant     one-hot owner of the current transfer, zero when idle
//   tx_data   latched byte to the transmitter
//   tx_start  one-cycle start pulse to the transmitter
//   tx_busy   busy flag from the transmitter
//   err       one-cycle pulse when busy failed to rise in time
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | no transfer; arbitrate among pending requests
// START     | tx_start is high this cycle; timeout counter is cleared
// WAIT_BUSY | waiting for tx_busy to rise; counts toward BUSY_TO
// WAIT_DONE | frame in flight; ack when tx_busy falls

module uart_tx_rr_arbiter #(
    parameter int N       = 4,
    parameter int WIDTH   = 8,
    parameter int BUSY_TO = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req,
    input  logic [N*WIDTH-1:0]   req_data,
    output logic [N-1:0]         ack,
    output logic [N-1:0]         grant,
    output logic [WIDTH-1:0]     tx_data,
    output logic                 tx_start,
    input  logic                 tx_busy,
    output logic                 err
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = $clog2(BUSY_TO + 1);
    // The counter is compared before it increments, so the timeout fires on
    // the cycle it steps to BUSY_TO-1. That places ack/err exactly BUSY_TO
    // cycles after the tx_start cycle.
    localparam logic [CW-1:0] CNT_LAST = CW'(BUSY_TO - 2);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START     = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    state_t           state, state_nxt;
    logic [PW-1:0]    ptr, ptr_nxt;
    logic [PW-1:0]    win, win_nxt;
    logic [PW-1:0]    ptr_adv;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic [N-1:0]     grant_nxt, ack_nxt;
    logic [WIDTH-1:0] tx_data_nxt;
    logic             tx_start_nxt, err_nxt;

    logic [N-1:0]     req_elig;
    logic             pick_vld;
    logic [PW-1:0]    pick;

    // The requester being acked this cycle still shows req high until it
    // reacts to ack, so it is masked out of the IDLE scan that follows.
    always_comb begin
        int idx;
        idx      = 0;
        req_elig = req & ~ack;
        pick_vld = 1'b0;
        pick     = '0;
        for (int i = 0; i < N; i++) begin
            idx = int'(ptr) + i;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!pick_vld && req_elig[idx]) begin
                pick_vld = 1'b1;
                pick     = PW'(idx);
            end
        end
    end

    always_comb begin
        if (int'(win) >= N - 1) begin
            ptr_adv = '0;
        end else begin
            ptr_adv = win + PW'(1);
        end
    end

    always_comb begin
        state_nxt    = state;
        ptr_nxt      = ptr;
        win_nxt      = win;
        cnt_nxt      = cnt;
        grant_nxt    = grant;
        ack_nxt      = '0;
        err_nxt      = 1'b0;
        tx_start_nxt = 1'b0;
        tx_data_nxt  = tx_data;

        case (state)
            IDLE: begin
                if (pick_vld) begin
                    win_nxt         = pick;
                    grant_nxt       = '0;
                    grant_nxt[pick] = 1'b1;
                    tx_data_nxt     = req_data[pick*WIDTH +: WIDTH];
                    tx_start_nxt    = 1'b1;
                    state_nxt       = START;
                end
            end
            START: begin
                cnt_nxt   = '0;
                state_nxt = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (tx_busy) begin
                    state_nxt = WAIT_DONE;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                    if (cnt == CNT_LAST) begin
                        ack_nxt[win] = 1'b1;
                        err_nxt      = 1'b1;
                        grant_nxt    = '0;
                        ptr_nxt      = ptr_adv;
                        state_nxt    = IDLE;
                    end
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    ack_nxt[win] = 1'b1;
                    grant_nxt    = '0;
                    ptr_nxt      = ptr_adv;
                    state_nxt    = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= '0;
            win      <= '0;
            cnt      <= '0;
            grant    <= '0;
            ack      <= '0;
            err      <= 1'b0;
            tx_start <= 1'b0;
            tx_data  <= '0;
        end else begin
            state    <= state_nxt;
            ptr      <= ptr_nxt;
            win      <= win_nxt;
            cnt      <= cnt_nxt;
            grant    <= grant_nxt;
            ack      <= ack_nxt;
            err      <= err_nxt;
            tx_start <= tx_start_nxt;
            tx_data  <= tx_data_nxt;
        end
    end

endmodule

// File: tb/tb_uart_tx_rr_arbiter.sv
// Bench for uart_tx_rr_arbiter. A small transmitter model raises busy for
// FRAME cycles after each accepted start and records the byte it would have
// sent. Clearing model_en turns it into a stub whose busy never rises.

module tb_uart_tx_rr_arbiter;

    localparam int N       = 4;
    localparam int WIDTH   = 8;
    localparam int BUSY_TO = 8;
    localparam int FRAME   = 10;

    logic               clk = 1'b0;
    logic               rst;
    logic [N-1:0]       req;
    logic [N*WIDTH-1:0] req_data;
    logic [N-1:0]       ack;
    logic [N-1:0]       grant;
    logic [WIDTH-1:0]   tx_data;
    logic               tx_start;
    logic               tx_busy;
    logic               err;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int t_start, t_ack;

    logic             model_en;
    logic [WIDTH-1:0] rx_q[$];
    logic [WIDTH-1:0] t2_d[4] = '{8'h2D, 8'h05, 8'h61, 8'h03};

    uart_tx_rr_arbiter #(.N(N), .WIDTH(WIDTH), .BUSY_TO(BUSY_TO)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .req_data (req_data),
        .ack      (ack),
        .grant    (grant),
        .tx_data  (tx_data),
        .tx_start (tx_start),
        .tx_busy  (tx_busy),
        .err      (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Transmitter model: ignores start while busy, cleared by rst.
    initial begin
        int left;
        left    = 0;
        tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                tx_busy = 1'b0;
                left    = 0;
            end else if (tx_busy) begin
                left = left - 1;
                if (left == 0) tx_busy = 1'b0;
            end else if (tx_start && model_en) begin
                tx_busy = 1'b1;
                left    = FRAME;
                rx_q.push_back(tx_data);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_data(input int k, input logic [WIDTH-1:0] d);
        req_data[k*WIDTH +: WIDTH] = d;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        rx_q.delete();
    endtask

    task automatic wait_start(input string tag, input logic [N-1:0] exp_grant,
                              input logic [WIDTH-1:0] exp_data);
        for (int i = 0; i < 40 && !tx_start; i++) @(negedge clk);
        t_start = cyc;
        chk({tag, "_start"}, 32'(tx_start), 32'd1);
        chk({tag, "_grant"}, 32'(grant), 32'(exp_grant));
        chk({tag, "_data"},  32'(tx_data), 32'(exp_data));
    endtask

    task automatic wait_ack(input string tag, input logic [N-1:0] exp_ack, input logic exp_err);
        for (int i = 0; i < 60 && ack == '0; i++) @(negedge clk);
        t_ack = cyc;
        chk({tag, "_ack"},       32'(ack),   32'(exp_ack));
        chk({tag, "_err"},       32'(err),   32'(exp_err));
        chk({tag, "_grant_clr"}, 32'(grant), 32'd0);
        req = req & ~exp_ack;
        @(negedge clk);
        chk({tag, "_ack_once"}, 32'(ack), 32'd0);
        chk({tag, "_err_once"}, 32'(err), 32'd0);
    endtask

    task automatic chk_rx(input string tag, input logic [WIDTH-1:0] exp);
        logic [31:0] v;
        v = 'x;
        if (rx_q.size() > 0) v = 32'(rx_q.pop_front());
        chk(tag, v, 32'(exp));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int ns;
        rst      = 1'b1;
        req      = '0;
        req_data = '0;
        model_en = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_grant",    32'(grant),    32'd0);
        chk("rst_ack",      32'(ack),      32'd0);
        chk("rst_tx_start", 32'(tx_start), 32'd0);
        chk("rst_err",      32'(err),      32'd0);
        chk("rst_tx_data",  32'(tx_data),  32'd0);
        rst = 1'b0;
        @(negedge clk);

        // single request, one-cycle latency to tx_start
        set_data(0, 8'h2D);
        req = 4'b0001;
        @(negedge clk);
        chk("t1_latency", 32'(tx_start), 32'd1);
        wait_start("t1", 4'b0001, 8'h2D);
        wait_ack("t1", 4'b0001, 1'b0);
        chk_rx("t1_rx", 8'h2D);

        // all four pending: served 0,1,2,3
        do_reset();
        for (int k = 0; k < 4; k++) set_data(k, t2_d[k]);
        req = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            wait_start($sformatf("t2_%0d", k), 4'(1 << k), t2_d[k]);
            wait_ack($sformatf("t2_%0d", k), 4'(1 << k), 1'b0);
            chk_rx($sformatf("t2_%0d_rx", k), t2_d[k]);
        end

        // wrap-around: after serving 2, scan starts at 3 and finds 0 first
        do_reset();
        set_data(2, 8'hA7);
        req = 4'b0100;
        wait_start("t3a", 4'b0100, 8'hA7);
        wait_ack("t3a", 4'b0100, 1'b0);
        chk_rx("t3a_rx", 8'hA7);
        set_data(0, 8'h3C);
        req = 4'b0101;
        wait_start("t3_0", 4'b0001, 8'h3C);
        wait_ack("t3_0", 4'b0001, 1'b0);
        chk_rx("t3_0_rx", 8'h3C);
        wait_start("t3_2", 4'b0100, 8'hA7);
        wait_ack("t3_2", 4'b0100, 1'b0);
        chk_rx("t3_2_rx", 8'hA7);

        // busy never rises: abandon after BUSY_TO cycles, then grant again
        model_en = 1'b0;
        set_data(1, 8'h99);
        req = 4'b0010;
        wait_start("t4", 4'b0010, 8'h99);
        wait_ack("t4", 4'b0010, 1'b1);
        chk("t4_to_cycles", 32'(t_ack - t_start), 32'(BUSY_TO));
        req = 4'b0010;
        wait_start("t4b", 4'b0010, 8'h99);
        wait_ack("t4b", 4'b0010, 1'b1);
        chk("t4b_to_cycles", 32'(t_ack - t_start), 32'(BUSY_TO));
        model_en = 1'b1;

        // reset during WAIT_DONE: outputs clear, ptr back to 0
        set_data(0, 8'h11);
        set_data(3, 8'h77);
        req = 4'b1001;
        wait_start("t5a", 4'b1000, 8'h77);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("t5_rst_grant",    32'(grant),    32'd0);
        chk("t5_rst_ack",      32'(ack),      32'd0);
        chk("t5_rst_tx_start", 32'(tx_start), 32'd0);
        chk("t5_rst_err",      32'(err),      32'd0);
        chk("t5_rst_tx_data",  32'(tx_data),  32'd0);
        @(negedge clk);
        rst = 1'b0;
        rx_q.delete();
        wait_start("t5_0", 4'b0001, 8'h11);
        wait_ack("t5_0", 4'b0001, 1'b0);
        chk_rx("t5_0_rx", 8'h11);
        wait_start("t5_3", 4'b1000, 8'h77);
        wait_ack("t5_3", 4'b1000, 1'b0);
        chk_rx("t5_3_rx", 8'h77);

        // req dropped during WAIT_DONE: frame still completes and acks
        set_data(1, 8'h5A);
        req = 4'b0010;
        wait_start("t6", 4'b0010, 8'h5A);
        repeat (3) @(negedge clk);
        req = 4'b0000;
        wait_ack("t6", 4'b0010, 1'b0);
        chk_rx("t6_rx", 8'h5A);
        ns = 0;
        repeat (20) begin
            if (tx_start) ns++;
            @(negedge clk);
        end
        chk("t6_no_regrant", 32'(ns), 32'd0);
        chk("t6_grant_idle", 32'(grant), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
